// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared types and constants for the AXI-Stream egress slice.
//   axis_beat_t     : one stream beat {tdata, tlast, tuser} at the default
//                     widths, used wherever a whole beat is handled as a unit
//   AXIS_CNT_W      : width of the optional statistics counters
//   egress_state_t  : inter-frame gap state machine encoding
// ---------------------------------------------------------------------------
package axis_pkg;

   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_USER_W = 1;
   localparam int AXIS_CNT_W  = 32;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] tdata;
      logic                   tlast;
      logic [AXIS_USER_W-1:0] tuser;
   } axis_beat_t;

   typedef enum logic [0:0] {
      ST_PASS = 1'b0,
      ST_GAP  = 1'b1
   } egress_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// ---------------------------------------------------------------------------
// axis_skid_buf
// Two-entry skid buffer: an output register OUT backed by one skid register
// SKID. The upstream ready is a flop (~skid full), so it never depends
// combinationally on the downstream ready. Beats flow in order, one per cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_beat, s_valid     : upstream beat (packed) and its valid
//   s_ready             : registered ready toward upstream
//   out_beat, out_valid : contents/occupancy of the OUT register
//   out_ready           : downstream accepts OUT this cycle (only meaningful
//                         while out_valid is high)
// ---------------------------------------------------------------------------
module axis_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_beat,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] out_beat,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] out_beat_q, out_beat_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] skid_beat_q, skid_beat_d;
   logic             skid_valid_q, skid_valid_d;
   logic             s_ready_q, s_ready_d;
   logic             s_hs;
   logic             out_free;

   // OUT can take a new beat when it is empty or is being consumed this cycle.
   // A held SKID beat always moves first so ordering is preserved; a new
   // upstream beat only lands in SKID while OUT is stalled.
   always_comb begin
      out_beat_d   = out_beat_q;
      out_valid_d  = out_valid_q;
      skid_beat_d  = skid_beat_q;
      skid_valid_d = skid_valid_q;
      s_hs         = s_valid & s_ready_q;
      out_free     = ~out_valid_q | out_ready;

      if (out_free) begin
         if (skid_valid_q) begin
            out_beat_d   = skid_beat_q;
            out_valid_d  = 1'b1;
            skid_valid_d = s_hs;
            if (s_hs) begin
               skid_beat_d = s_beat;
            end
         end else begin
            out_valid_d = s_hs;
            if (s_hs) begin
               out_beat_d = s_beat;
            end
         end
      end else if (s_hs) begin
         skid_beat_d  = s_beat;
         skid_valid_d = 1'b1;
      end

      // Ready looks at the next SKID occupancy so it drops the cycle after
      // SKID fills and rises the cycle after it drains.
      s_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_beat_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_beat_q  <= '0;
         skid_valid_q <= 1'b0;
         s_ready_q    <= 1'b0;
      end else begin
         out_beat_q   <= out_beat_d;
         out_valid_q  <= out_valid_d;
         skid_beat_q  <= skid_beat_d;
         skid_valid_q <= skid_valid_d;
         s_ready_q    <= s_ready_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign out_beat  = out_beat_q;
   assign out_valid = out_valid_q;

endmodule

// File: rtl/axis_egress.sv
// ---------------------------------------------------------------------------
// axis_egress
// Egress boundary of the parser datapath: internal AXI-Stream (s_*) to the
// external AXI-Stream (m_*). All m_* outputs come straight from registers.
// A skid buffer decouples s_tready from m_tready, and after every frame end
// m_tvalid is held low for IFG_CYCLES cycles (0 = no gap).
// Optional feature macro: AXIS_EGRESS_STATS_EN adds frame_cnt / beat_cnt.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast/s_tuser    : internal stream in
//   s_tready                            : registered ready toward internal side
//   m_tdata/m_tvalid/m_tlast/m_tuser    : external stream out
//   m_tready                            : external backpressure
//   frame_cnt, beat_cnt                 : frames / beats sent (macro only)
// ---------------------------------------------------------------------------
module axis_egress
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int IFG_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [USER_WIDTH-1:0] s_tuser,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [USER_WIDTH-1:0] m_tuser
`ifdef AXIS_EGRESS_STATS_EN
   ,
   output logic [AXIS_CNT_W-1:0] frame_cnt,
   output logic [AXIS_CNT_W-1:0] beat_cnt
`endif
);

   localparam int BEAT_W = DATA_WIDTH + 1 + USER_WIDTH;
   localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

   logic [BEAT_W-1:0] s_beat;
   logic [BEAT_W-1:0] out_beat;
   logic              out_valid;
   logic              gap_active;
   logic              m_hs;
   egress_state_t     state_q;
   logic [GAP_W-1:0]  gap_cnt_q;

   // Beat layout inside the buffer: {tdata, tlast, tuser}, matching axis_beat_t.
   assign s_beat = {s_tdata, s_tlast, s_tuser};

   axis_skid_buf #(
      .WIDTH (BEAT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_beat    (s_beat),
      .s_valid   (s_tvalid),
      .s_ready   (s_tready),
      .out_beat  (out_beat),
      .out_valid (out_valid),
      .out_ready (m_tready & ~gap_active)
   );

   assign gap_active = (state_q == ST_GAP);
   assign m_tvalid   = out_valid & ~gap_active;
   assign m_tdata    = out_beat[BEAT_W-1 -: DATA_WIDTH];
   assign m_tlast    = out_beat[USER_WIDTH];
   assign m_tuser    = out_beat[USER_WIDTH-1:0];
   assign m_hs       = m_tvalid & m_tready;

   // Gap FSM: a frame-end handshake parks the output for IFG_CYCLES cycles.
   // The counter starts at IFG_CYCLES-1 and the exit happens on the cycle it
   // reads 0, so exactly IFG_CYCLES cycles are spent in GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_PASS;
         gap_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_PASS: begin
               if (m_hs && m_tlast && (IFG_CYCLES > 0)) begin
                  state_q   <= ST_GAP;
                  gap_cnt_q <= GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q <= ST_PASS;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_PASS;
            end
         endcase
      end
   end

`ifdef AXIS_EGRESS_STATS_EN
   logic [AXIS_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [AXIS_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   // Counters wrap naturally at 2^32.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      if (m_hs) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
         if (m_tlast) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_egress.sv
// ---------------------------------------------------------------------------
// tb_axis_egress
// Bench for axis_egress with IFG_CYCLES = 3. A queue-based model holds every
// beat accepted on s_* and not yet delivered on m_*; on every falling edge the
// DUT outputs are compared with what that queue and the inter-frame gap rules
// demand. Directed sections pin the model with literal expectations, then a
// long random run exercises arbitrary valid/ready patterns.
// Build with +define+AXIS_EGRESS_STATS_EN to cover the statistics counters.
// ---------------------------------------------------------------------------
module tb_axis_egress;
   import axis_pkg::*;

   localparam int IFG = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [0:0]  s_tuser;
   logic [63:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [0:0]  m_tuser;
`ifdef AXIS_EGRESS_STATS_EN
   logic [31:0] frame_cnt;
   logic [31:0] beat_cnt;
`endif

   axis_egress #(
      .DATA_WIDTH (64),
      .USER_WIDTH (1),
      .IFG_CYCLES (IFG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .s_tuser   (s_tuser),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .m_tuser   (m_tuser)
`ifdef AXIS_EGRESS_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .beat_cnt  (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: beats in flight, with the cycle each one was accepted.
   typedef struct {
      axis_beat_t beat;
      int         cyc;
   } model_entry_t;

   model_entry_t model_q[$];
   int          gap_left = 0;
   int          edges_since_release = 0;
   int          cycle = 0;
   logic [31:0] model_frames = '0;
   logic [31:0] model_beats = '0;

   // Log of every delivered beat, used by the directed sections.
   logic [63:0] log_data[$];
   bit          log_last[$];
   int          log_cyc[$];
   int          log_lat[$];

   // Records one comparison; every mismatch is reported on its own line.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Offers one beat on s_* and holds it until accepted (bounded wait).
   // Called and returns 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [63:0] data, input logic last, input logic user);
      bit accepted;
      int budget;
      accepted = 1'b0;
      budget   = 0;
      s_tdata  = data;
      s_tlast  = last;
      s_tuser  = user;
      s_tvalid = 1'b1;
      while (!accepted && budget < 20) begin
         @(negedge clk);
         accepted = (s_tready === 1'b1) && (rst_n === 1'b1);
         @(posedge clk);
         #1;
         budget++;
      end
      s_tvalid = 1'b0;
      if (!accepted) checkOutput("s_handshake_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitDelivered(input int n);
      int budget;
      budget = 0;
      while (log_data.size() < n && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (log_data.size() < n) checkOutput("deliver_timeout", 64'(log_data.size()), 64'(n));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare process: outputs are stable at the falling edge. The model
   // demands that m_tvalid is high exactly when a beat is in flight and no
   // gap cycle is pending, that the presented beat is the oldest one in
   // flight, and that s_tready is high exactly when fewer than two beats are
   // buffered (except on the very first cycle out of reset).
   always @(negedge clk) begin
      bit          exp_valid;
      bit          s_hs;
      bit          m_hs;
      axis_beat_t  nb;
      model_entry_t ent;
      if (rst_n !== 1'b1) begin
         checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
         checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
         checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
         checkOutput("rst_m_tdata", m_tdata, 64'd0);
         model_q.delete();
         gap_left = 0;
         edges_since_release = 0;
         model_frames = '0;
         model_beats = '0;
      end else begin
         exp_valid = (model_q.size() != 0) && (gap_left == 0);
         checkOutput("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
         if (m_tvalid && model_q.size() != 0) begin
            checkOutput("m_tdata", m_tdata, model_q[0].beat.tdata);
            checkOutput("m_tlast", 64'(m_tlast), 64'(model_q[0].beat.tlast));
            checkOutput("m_tuser", 64'(m_tuser), 64'(model_q[0].beat.tuser));
         end
         checkOutput("s_tready", 64'(s_tready),
                     64'((edges_since_release != 0) && (model_q.size() < 2)));
`ifdef AXIS_EGRESS_STATS_EN
         checkOutput("frame_cnt", 64'(frame_cnt), 64'(model_frames));
         checkOutput("beat_cnt", 64'(beat_cnt), 64'(model_beats));
`endif
         s_hs = s_tvalid && s_tready;
         m_hs = m_tvalid && m_tready;
         if (gap_left > 0) gap_left--;
         if (m_hs) begin
            if (model_q.size() != 0) begin
               ent = model_q.pop_front();
               log_lat.push_back(cycle - ent.cyc);
            end else begin
               log_lat.push_back(-1);
            end
            log_data.push_back(m_tdata);
            log_last.push_back(m_tlast);
            log_cyc.push_back(cycle);
            model_beats = model_beats + 32'd1;
            if (m_tlast) begin
               gap_left = IFG;
               model_frames = model_frames + 32'd1;
            end
         end
         if (s_hs) begin
            nb.tdata = s_tdata;
            nb.tlast = s_tlast;
            nb.tuser = s_tuser;
            ent.beat = nb;
            ent.cyc  = cycle;
            model_q.push_back(ent);
         end
         if (edges_since_release < 2) edges_since_release++;
      end
      cycle++;
   end

   initial begin
      int base;
      rst_n    = 1'b0;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = '0;
      m_tready = 1'b0;

      // Reset held for three cycles, then released away from the edge.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("reset_s_tready", 64'(s_tready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release_s_tready", 64'(s_tready), 64'd1);

      // Streaming 0x11..0x18, one per cycle, tlast on the last.
      $display("[TB] streaming");
      m_tready = 1'b1;
      base = log_data.size();
      for (int i = 0; i < 8; i++) applyStimulus(64'h11 + 64'(i), (i == 7), 1'(i));
      waitDelivered(base + 8);
      if (log_data.size() >= base + 8) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("stream_data", log_data[base+i], 64'h11 + 64'(i));
            checkOutput("stream_last", 64'(log_last[base+i]), 64'(i == 7));
            checkOutput("stream_latency", 64'(log_lat[base+i]), 64'd1);
         end
      end
      idle(8);

      // Backpressure: two beats into a stalled output.
      $display("[TB] backpressure");
      m_tready = 1'b0;
      applyStimulus(64'h1122334455667788, 1'b0, 1'b0);
      applyStimulus(64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1);
      checkOutput("bp_s_tready_low", 64'(s_tready), 64'd0);
      checkOutput("bp_held_data", m_tdata, 64'h1122334455667788);
      idle(3);
      checkOutput("bp_still_valid", 64'(m_tvalid), 64'd1);
      checkOutput("bp_still_held", m_tdata, 64'h1122334455667788);
      base = log_data.size();
      m_tready = 1'b1;
      waitDelivered(base + 2);
      if (log_data.size() >= base + 2) begin
         checkOutput("bp_first_out", log_data[base], 64'h1122334455667788);
         checkOutput("bp_second_out", log_data[base+1], 64'hAAAAAAAAAAAAAAAA);
      end
      idle(8);

      // Gap: two single-beat frames back to back.
      $display("[TB] inter-frame gap");
      base = log_data.size();
      applyStimulus(64'h21, 1'b1, 1'b0);
      applyStimulus(64'h22, 1'b1, 1'b1);
      waitDelivered(base + 2);
      if (log_data.size() >= base + 2) begin
         checkOutput("gap_spacing", 64'(log_cyc[base+1] - log_cyc[base]), 64'(IFG + 1));
      end
      idle(8);

      // Reset with both registers full.
      $display("[TB] mid-frame reset");
      m_tready = 1'b0;
      applyStimulus(64'h31, 1'b0, 1'b0);
      applyStimulus(64'h32, 1'b0, 1'b0);
      checkOutput("mid_full_s_tready", 64'(s_tready), 64'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("mid_rst_m_tdata", m_tdata, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_tready = 1'b1;
      base = log_data.size();
      idle(10);
      checkOutput("mid_no_stale_beat", 64'(log_data.size()), 64'(base));

`ifdef AXIS_EGRESS_STATS_EN
      // Statistics: 5 frames of 4 beats from a fresh reset.
      $display("[TB] statistics");
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      for (int f = 0; f < 5; f++)
         for (int b = 0; b < 4; b++)
            applyStimulus(64'(f * 16 + b), (b == 3), 1'b0);
      idle(30);
      checkOutput("stats_frame_cnt", 64'(frame_cnt), 64'd5);
      checkOutput("stats_beat_cnt", 64'(beat_cnt), 64'd20);
      force dut.beat_cnt_q = 32'hFFFF_FFFF;
      release dut.beat_cnt_q;
      model_beats = 32'hFFFF_FFFF;
      applyStimulus(64'h99, 1'b0, 1'b0);
      idle(3);
      checkOutput("stats_beat_wrap", 64'(beat_cnt), 64'd0);
`endif

      // Random traffic against the model, then drain.
      $display("[TB] random traffic");
      repeat (3000) begin
         s_tvalid = ($urandom_range(0, 9) < 7);
         s_tdata  = {$urandom(), $urandom()};
         s_tlast  = ($urandom_range(0, 3) == 0);
         s_tuser  = 1'($urandom_range(0, 1));
         m_tready = ($urandom_range(0, 9) < 6);
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      idle(30);
      checkOutput("drain_empty", 64'(model_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
